// File: rtl/rsa_uart_host.sv
// Host-side initiator for the UART-attached RSA engine: sends a {plain, key, mod}
// frame MSB-byte-first into the UART TX FIFO and collects the one-word result from RX.
module rsa_uart_host #(
  parameter int WordSize       = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WordSize-1:0] plain_text,
  input  logic [WordSize-1:0] key,
  input  logic [WordSize-1:0] mod,
  output logic [7:0]          w_data,
  output logic                wr_uart,
  input  logic                tx_full,
  input  logic [7:0]          r_data,
  output logic                rd_uart,
  input  logic                rx_empty,
  output logic [WordSize-1:0] result,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  localparam int NB      = WordSize / 8;
  localparam int FRAME_B = 3 * NB;
  localparam int CW      = $clog2(FRAME_B + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, FLUSH, SEND, RECV} state_t;

  state_t                  state, state_nxt;
  logic [3*WordSize-1:0]   tx_sr;
  logic [WordSize-1:0]     rx_sr;
  logic [WordSize-1:0]     rx_word;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           tout_cnt;
  logic                    tx_last, rx_last, rx_last_pop, tout_hit;

  always_comb begin
    wr_uart     = (state == SEND) && !tx_full;
    rd_uart     = ((state == FLUSH) || (state == RECV)) && !rx_empty;
    w_data      = (state == SEND) ? tx_sr[3*WordSize-1 -: 8] : 8'h00;
    rx_word     = WordSize'({rx_sr, r_data});
    tx_last     = (cnt == CW'(FRAME_B - 1));
    rx_last     = (cnt == CW'(NB - 1));
    rx_last_pop = (state == RECV) && rd_uart && rx_last;
    // The counter reaches TIMEOUT_CYCLES-1 on the edge that ends this cycle.
    tout_hit    = (state == RECV) && rx_empty && (tout_cnt == TW'(TIMEOUT_CYCLES - 2));

    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FLUSH;
      FLUSH:   if (rx_empty) state_nxt = SEND;
      SEND:    if (wr_uart && tx_last) state_nxt = RECV;
      RECV:    if (rx_last_pop || tout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tout_cnt <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= rx_last_pop;
      timeout <= tout_hit;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            tout_cnt <= '0;
          end
        end
        SEND: begin
          if (wr_uart) cnt <= tx_last ? '0 : cnt + CW'(1);
        end
        RECV: begin
          if (rd_uart) begin
            cnt      <= cnt + CW'(1);
            tout_cnt <= '0;
            if (rx_last) result <= rx_word;
          end else begin
            tout_cnt <= tout_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Shift registers carry data only; the state machine decides when they matter.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      tx_sr <= {plain_text, key, mod};
      rx_sr <= '0;
    end else if (wr_uart) begin
      tx_sr <= {tx_sr[3*WordSize-9:0], 8'h00};
    end else if ((state == RECV) && rd_uart) begin
      rx_sr <= rx_word;
    end
  end

endmodule

// File: tb/tb_rsa_uart_host.sv
// Bench for rsa_uart_host: queue-based UART FIFO peer plus a frame/latency reference model.
module tb_rsa_uart_host;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset, start, tx_full, rd_uart, wr_uart, rx_empty;
  logic [31:0] plain_text, key, mod, result;
  logic [7:0]  w_data, r_data;
  logic        busy, done, timeout;

  rsa_uart_host #(.WordSize(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .plain_text(plain_text), .key(key), .mod(mod),
    .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full),
    .r_data(r_data), .rd_uart(rd_uart), .rx_empty(rx_empty),
    .result(result), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  logic [7:0]  rxq[$];
  logic [7:0]  tx_log[$];
  logic        busy_q[$];
  logic [7:0]  resp_b[4];
  int          resp_n_g, bp_after_g, bp_len_g, bp_left;
  bit          pend_pop, pend_resp, in_txn;
  int          cyc_n, rd_pre, done_cyc, to_cyc, both, wr_full;
  logic [31:0] exp_result;
  logic        o_wr, o_rd, o_busy, o_done, o_to;
  logic [7:0]  o_wd;
  logic [31:0] o_res;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  // One clock: apply peer effects of the previous cycle just after the edge,
  // then observe the DUT mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pend_pop && rxq.size() != 0) void'(rxq.pop_front());
    pend_pop = 1'b0;
    if (pend_resp) for (int j = 0; j < resp_n_g; j++) rxq.push_back(resp_b[j]);
    pend_resp = 1'b0;
    if (bp_left > 0) begin
      tx_full = 1'b1;
      bp_left--;
    end else begin
      tx_full = 1'b0;
    end
    drive_rx();
    cyc_n++;
    @(negedge clk);
    o_wr = wr_uart; o_rd = rd_uart; o_wd = w_data; o_busy = busy;
    o_done = done; o_to = timeout; o_res = result;
    if (rd_uart) pend_pop = 1'b1;
    if (in_txn) begin
      busy_q.push_back(busy);
      if (wr_uart) begin
        if (tx_full) wr_full++;
        tx_log.push_back(w_data);
        if (tx_log.size() == bp_after_g) bp_left = bp_len_g;
        if (tx_log.size() == 12) pend_resp = 1'b1;
      end
      if (rd_uart && tx_log.size() == 0) rd_pre++;
      if (done && done_cyc < 0) done_cyc = cyc_n;
      if (timeout && to_cyc < 0) to_cyc = cyc_n;
      if (done && timeout) both++;
    end
  endtask

  task automatic run_txn(input string tag, input logic [31:0] p, input logic [31:0] k,
                         input logic [31:0] m, input logic [31:0] rw, input int stale,
                         input int bp_after, input int bp_len, input int resp_n,
                         input int glitch_at);
    logic [95:0] frame;
    int          flush, send, exp_end, busy_err;
    frame = {p, k, m};
    tx_log.delete(); busy_q.delete();
    rd_pre = 0; done_cyc = -1; to_cyc = -1; both = 0; wr_full = 0;
    for (int j = 0; j < 4; j++) resp_b[j] = rw[31-8*j -: 8];
    resp_n_g = resp_n; bp_after_g = bp_after; bp_len_g = bp_len;
    for (int j = 0; j < stale; j++) rxq.push_back(8'($urandom));
    drive_rx();
    plain_text = p; key = k; mod = m;
    start = 1'b1; cyc_n = 0; in_txn = 1'b1;
    while (done_cyc < 0 && to_cyc < 0 && cyc_n < 400) begin
      tick();
      start = (glitch_at > 0) && (cyc_n == glitch_at);
      if (start) begin
        plain_text = ~p; key = ~k; mod = ~m;
      end
    end
    in_txn = 1'b0;

    flush   = stale + 1;
    send    = 12 + bp_len;
    exp_end = (resp_n == 4) ? 1 + flush + send + 4 : flush + send + resp_n + TO;
    chk({tag, ".tx_count"}, tx_log.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("%s.tx_byte%0d", tag, i),
          (i < tx_log.size()) ? {88'd0, tx_log[i]} : {96{1'bx}}, frame[95-8*i -: 8]);
    chk({tag, ".flush_pops"}, rd_pre, stale);
    if (resp_n == 4) begin
      chk({tag, ".done_cycle"}, done_cyc, exp_end);
      chk({tag, ".no_timeout"}, to_cyc, -1);
      exp_result = rw;
    end else begin
      chk({tag, ".timeout_cycle"}, to_cyc, exp_end);
      chk({tag, ".no_done"}, done_cyc, -1);
    end
    chk({tag, ".result"}, result, exp_result);
    busy_err = 0;
    for (int c = 1; c <= busy_q.size(); c++)
      if (busy_q[c-1] !== (c < exp_end)) busy_err++;
    chk({tag, ".busy_pattern_errs"}, busy_err, 0);
    chk({tag, ".wr_while_full"}, wr_full, 0);
    chk({tag, ".done_and_timeout"}, both, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
    plain_text = '0; key = '0; mod = '0;
    pend_pop = 0; pend_resp = 0; in_txn = 0; bp_left = 0; bp_after_g = 0; bp_len_g = 0;
    resp_n_g = 0; cyc_n = 0; exp_result = 32'h0;
    repeat (3) tick();
    chk("rst.busy", o_busy, 1'b0);
    chk("rst.done", o_done, 1'b0);
    chk("rst.timeout", o_to, 1'b0);
    chk("rst.wr_uart", o_wr, 1'b0);
    chk("rst.rd_uart", o_rd, 1'b0);
    chk("rst.w_data", o_wd, 8'h00);
    chk("rst.result", o_res, 32'h0);
    reset = 1'b0;
    tick();

    run_txn("normal", 32'h00000041, 32'h00010001, 32'h0BADF00D, 32'h12345678, 0, 0, 0, 4, 0);
    for (int r = 0; r < 3; r++)
      run_txn($sformatf("rand%0d", r), $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(1, 11), $urandom_range(0, 6), 4, 0);
    run_txn("backpressure", 32'h00000041, 32'h00010001, 32'h0BADF00D, $urandom, 0, 3, 5, 4, 0);
    run_txn("stale_rx", $urandom, $urandom, $urandom, $urandom, 3, 0, 0, 4, 0);
    run_txn("timeout", $urandom, $urandom, $urandom, $urandom, 0, 0, 0, 2, 0);
    run_txn("after_timeout", $urandom, $urandom, $urandom, $urandom, 0, 0, 0, 4, 0);
    run_txn("start_in_send", $urandom, $urandom, $urandom, $urandom, 0, 0, 0, 4, 5);

    tx_log.delete(); busy_q.delete();
    bp_after_g = 0; bp_len_g = 0; resp_n_g = 4; done_cyc = -1; to_cyc = -1;
    plain_text = $urandom; key = $urandom; mod = $urandom;
    start = 1'b1; cyc_n = 0; in_txn = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 50 && tx_log.size() < 5; g++) tick();
    reset = 1'b1;
    tick();
    chk("midrst.busy", o_busy, 1'b0);
    chk("midrst.done", o_done, 1'b0);
    chk("midrst.timeout", o_to, 1'b0);
    chk("midrst.wr_uart", o_wr, 1'b0);
    chk("midrst.rd_uart", o_rd, 1'b0);
    chk("midrst.w_data", o_wd, 8'h00);
    chk("midrst.result", o_res, 32'h0);
    reset = 1'b0;
    repeat (6) tick();
    chk("midrst.tx_count_frozen", tx_log.size(), 5);
    chk("midrst.busy_after", o_busy, 1'b0);
    chk("midrst.no_done", done_cyc, -1);
    in_txn = 1'b0;
    exp_result = 32'h0;
    run_txn("after_reset", $urandom, $urandom, $urandom, $urandom, 0, 0, 0, 4, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
